// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - sequencer <-> datapath/memory signal bundle
// Step exists only when SEQ_SINGLE_STEP_EN is defined.
interface instr_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             Branch;
  logic             Taken;
  logic [PC_W-1:0]  Target;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             Halt;
  logic             MemAck;
`ifdef SEQ_SINGLE_STEP_EN
  logic             Step;
`endif
  logic [PC_W-1:0]  PC;
  logic             InstrEn;
  logic             MemReq;
  logic             MemWe;
  logic             RegWe;
  logic             Done;
  logic [CNT_W-1:0] CycleCount;

  modport master (
`ifdef SEQ_SINGLE_STEP_EN
    input  Step,
`endif
    input  Start, StartAddr, Branch, Taken, Target,
    input  MemWrite, MemtoReg, RegWrite, Halt, MemAck,
    output PC, InstrEn, MemReq, MemWe, RegWe, Done, CycleCount
  );

  modport slave (
`ifdef SEQ_SINGLE_STEP_EN
    output Step,
`endif
    output Start, StartAddr, Branch, Taken, Target,
    output MemWrite, MemtoReg, RegWrite, Halt, MemAck,
    input  PC, InstrEn, MemReq, MemWe, RegWe, Done, CycleCount
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit CPU
// Optional single-step PAUSE state enabled by SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input logic               Clk,
  input logic               Reset,
  instr_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, PAUSE
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, tgt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             start_ok, counting;
  logic             instr_en, mem_req, mem_we, reg_we, done;

  assign start_ok = bus.Start && (state_q == IDLE || state_q == HALTED);
  assign counting = !(state_q inside {IDLE, HALTED, PAUSE});

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    instr_en = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    reg_we   = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE:    if (bus.Start) state_d = FETCH;
      FETCH: begin
        instr_en = 1'b1;
        state_d  = DECODE;
      end
      DECODE:  state_d = bus.Halt ? HALTED : EXEC;
      EXEC:    state_d = (bus.MemWrite || bus.MemtoReg) ? MEM : WB;
      MEM: begin
        mem_req = 1'b1;
        mem_we  = bus.MemWrite;
        if (bus.MemAck) state_d = WB;
      end
      WB: begin
        reg_we = bus.RegWrite;
`ifdef SEQ_SINGLE_STEP_EN
        state_d = PAUSE;
`else
        state_d = FETCH;
`endif
      end
      HALTED: begin
        done = 1'b1;
        if (bus.Start) state_d = FETCH;
      end
`ifdef SEQ_SINGLE_STEP_EN
      PAUSE:   if (bus.Step) state_d = FETCH;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Branch decision and target are captured in EXEC so WB is immune to decoder changes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      br_q  <= 1'b0;
      tgt_q <= '0;
    end else begin
      if (start_ok) begin
        pc_q  <= bus.StartAddr;
        cnt_q <= '0;
      end else begin
        if (counting && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        if (state_q == WB) pc_q <= br_q ? tgt_q : pc_q + PC_W'(1);
      end
      if (state_q == EXEC) begin
        br_q  <= bus.Taken & bus.Branch;
        tgt_q <= bus.Target;
      end
    end
  end

  // MemReq is also gated by Reset so the request drops the instant reset asserts.
  assign bus.PC         = pc_q;
  assign bus.InstrEn    = instr_en;
  assign bus.MemReq     = mem_req & Reset;
  assign bus.MemWe      = mem_we & Reset;
  assign bus.RegWe      = reg_we;
  assign bus.Done       = done;
  assign bus.CycleCount = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed table-driven bench for instr_sequencer
// Step cycles are inserted after WB rows when SEQ_SINGLE_STEP_EN is defined.
module tb_instr_sequencer;
  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  typedef struct {
    logic            start;
    logic [PC_W-1:0] saddr;
    logic            br, tk;
    logic [PC_W-1:0] tgt;
    logic            mw, mr, rw, halt, ack;
    logic            wb;
    logic [PC_W-1:0] pc;
    logic [4:0]      outs;
    logic            cc_en;
    logic [CNT_W-1:0] cc;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  instr_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
  instr_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs_now();
    return {bus.InstrEn, bus.MemReq, bus.MemWe, bus.RegWe, bus.Done};
  endfunction

  task automatic drive(input logic start, input logic [PC_W-1:0] saddr, input logic br,
                       input logic tk, input logic [PC_W-1:0] tgt, input logic mw,
                       input logic mr, input logic rw, input logic halt, input logic ack);
    bus.Start = start; bus.StartAddr = saddr; bus.Branch = br; bus.Taken = tk;
    bus.Target = tgt; bus.MemWrite = mw; bus.MemtoReg = mr; bus.RegWrite = rw;
    bus.Halt = halt; bus.MemAck = ack;
  endtask

  task automatic add(input logic start, input logic [PC_W-1:0] saddr, input logic br,
                     input logic tk, input logic [PC_W-1:0] tgt, input logic mw,
                     input logic mr, input logic rw, input logic halt, input logic ack,
                     input logic wb, input logic [PC_W-1:0] pc, input logic [4:0] outs,
                     input logic cc_en, input logic [CNT_W-1:0] cc);
    vec_t v;
    v.start = start; v.saddr = saddr; v.br = br; v.tk = tk; v.tgt = tgt;
    v.mw = mw; v.mr = mr; v.rw = rw; v.halt = halt; v.ack = ack; v.wb = wb;
    v.pc = pc; v.outs = outs; v.cc_en = cc_en; v.cc = cc;
    vq.push_back(v);
  endtask

  initial begin
    int nreq, nrwe, nmwe, seen;
    logic [CNT_W-1:0] frozen;
    logic ok;

    // outs = {InstrEn, MemReq, MemWe, RegWe, Done}
    // Program A: three register ops from 5, halt at 8
    add(1, 10'h005, 0,0,10'h000, 0,0,0,0,0, 0, 10'h000, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,0,0, 0, 10'h005, 5'b10000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 0, 10'h005, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 0, 10'h005, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 1, 10'h005, 5'b00010, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 0, 10'h006, 5'b10000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 0, 10'h006, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 0, 10'h006, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 1, 10'h006, 5'b00010, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 0, 10'h007, 5'b10000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 0, 10'h007, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 0, 10'h007, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,1,0,0, 1, 10'h007, 5'b00010, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,0,0, 0, 10'h008, 5'b10000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,1,0, 0, 10'h008, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,0,0, 0, 10'h008, 5'b00001, 1, 16'd14);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,0,1, 0, 10'h008, 5'b00001, 1, 16'd14);
    // Program B: not-taken branch at 3FF wraps, taken branch to 020, 1-cycle store, halt
    add(1, 10'h3FF, 0,0,10'h000, 0,0,0,0,0, 0, 10'h008, 5'b00001, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,0,0, 0, 10'h3FF, 5'b10000, 1, 16'd0);
    add(0, 10'h000, 1,0,10'h000, 0,0,0,0,0, 0, 10'h3FF, 5'b00000, 0, 0);
    add(0, 10'h000, 1,0,10'h020, 0,0,0,0,0, 0, 10'h3FF, 5'b00000, 0, 0);
    add(0, 10'h000, 1,1,10'h020, 0,0,0,0,0, 1, 10'h3FF, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,0,0, 0, 10'h000, 5'b10000, 0, 0);
    add(0, 10'h000, 1,0,10'h000, 0,0,0,0,0, 0, 10'h000, 5'b00000, 0, 0);
    add(0, 10'h000, 1,1,10'h020, 0,0,0,0,0, 0, 10'h000, 5'b00000, 0, 0);
    add(0, 10'h000, 1,0,10'h0AA, 0,0,0,0,0, 1, 10'h000, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,0,0, 0, 10'h020, 5'b10000, 0, 0);
    add(1, 10'h100, 0,0,10'h000, 1,0,0,0,0, 0, 10'h020, 5'b00000, 0, 0);
    add(1, 10'h100, 0,0,10'h000, 1,0,0,0,1, 0, 10'h020, 5'b00000, 0, 0);
    add(1, 10'h100, 0,0,10'h000, 1,0,0,0,1, 0, 10'h020, 5'b01100, 0, 0);
    add(1, 10'h100, 0,0,10'h000, 1,0,0,0,0, 1, 10'h020, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,0,0, 0, 10'h021, 5'b10000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,1,0, 0, 10'h021, 5'b00000, 0, 0);
    add(0, 10'h000, 0,0,10'h000, 0,0,0,0,0, 0, 10'h021, 5'b00001, 1, 16'd15);

    Reset = 1'b0;
    drive(0, '0, 0, 0, '0, 0, 0, 0, 0, 0);
`ifdef SEQ_SINGLE_STEP_EN
    bus.Step = 1'b1;
`endif
    #1;
    check("reset_pc_outs", {17'd0, bus.PC, outs_now()}, 32'd0);
    check("reset_cnt", {16'd0, bus.CycleCount}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge Clk);
      drive(vq[i].start, vq[i].saddr, vq[i].br, vq[i].tk, vq[i].tgt,
            vq[i].mw, vq[i].mr, vq[i].rw, vq[i].halt, vq[i].ack);
      #1;
      check($sformatf("vec%0d_pc_outs", i), {17'd0, bus.PC, outs_now()},
            {17'd0, vq[i].pc, vq[i].outs});
      if (vq[i].cc_en)
        check($sformatf("vec%0d_cnt", i), {16'd0, bus.CycleCount}, {16'd0, vq[i].cc});
`ifdef SEQ_SINGLE_STEP_EN
      if (vq[i].wb && i + 1 < vq.size()) begin
        @(negedge Clk);
        drive(0, '0, 0, 0, '0, 0, 0, 0, 0, 0);
        #1;
        check($sformatf("vec%0d_pause", i), {17'd0, bus.PC, outs_now()},
              {17'd0, vq[i+1].pc, 5'b00000});
      end
`endif
    end

    // Load from 0x040 acknowledged in the third MEM cycle
    @(negedge Clk);
    drive(1, 10'h040, 0, 0, '0, 0, 1, 1, 0, 0);
    @(negedge Clk);
    bus.Start = 1'b0;
    nreq = 0; nrwe = 0; nmwe = 0; seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      #1;
      if (c > 0 && bus.InstrEn) seen = 1;
      else begin
        if (bus.MemReq) begin
          nreq++;
          if (bus.MemWe) nmwe++;
        end
        if (bus.RegWe) nrwe++;
        bus.MemAck = bus.MemReq && nreq == 3;
        @(negedge Clk);
      end
    end
    check("load_next_fetch_seen", seen, 1);
    check("load_pc", {22'd0, bus.PC}, 32'h041);
    check("load_memreq_cycles", nreq, 3);
    check("load_memwe_cycles", nmwe, 0);
    check("load_regwe_pulses", nrwe, 1);
    check("load_cycles", {16'd0, bus.CycleCount}, 32'd7);
    drive(0, '0, 0, 0, '0, 0, 0, 0, 1, 0);
    @(negedge Clk);
    @(negedge Clk);
    #1;
    check("load_then_halt_done", {31'd0, bus.Done}, 32'd1);

    // Reset asserted while a load is waiting for MemAck
    @(negedge Clk);
    drive(1, 10'h050, 0, 0, '0, 0, 1, 0, 0, 0);
    @(negedge Clk);
    bus.Start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (bus.MemReq) ok = 1'b1;
      else @(negedge Clk);
    end
    check("rst_memreq_seen", {31'd0, ok}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("rst_memreq_drop", {31'd0, bus.MemReq}, 32'd0);
    check("rst_pc_done", {21'd0, bus.PC, bus.Done}, 32'd0);
    check("rst_cnt", {16'd0, bus.CycleCount}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    bus.MemtoReg = 1'b0;
    @(negedge Clk);
    #1;
    check("post_rst_idle", {17'd0, bus.PC, outs_now()}, 32'd0);
    check("post_rst_cnt", {16'd0, bus.CycleCount}, 32'd0);

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: PAUSE holds with Step=0, releases to FETCH on Step=1
    @(negedge Clk);
    drive(1, 10'h060, 0, 0, '0, 0, 0, 1, 0, 0);
    bus.Step = 1'b0;
    @(negedge Clk);
    bus.Start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (bus.RegWe) ok = 1'b1;
      else @(negedge Clk);
    end
    check("step_wb_seen", {31'd0, ok}, 32'd1);
    @(negedge Clk);
    #1;
    frozen = bus.CycleCount;
    check("step_cnt_at_pause", {16'd0, frozen}, 32'd4);
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      #1;
      if (bus.InstrEn || bus.CycleCount != frozen) nreq++;
    end
    check("step_pause_hold", nreq, 0);
    bus.Step = 1'b1;
    @(negedge Clk);
    #1;
    check("step_release_fetch", {21'd0, bus.PC, bus.InstrEn}, {21'd0, 10'h061, 1'b1});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
